alu_arb_sequencer: RTL and testbench

ALU_ARB_SEQUENCER -- requirements
Module: alu_arb_sequencer

---
 rtl/alu_arb_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_arb_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arb_sequencer.sv
// Two-requester round-robin front end for a registered arithmetic unit.
// One command in flight; the result is held until the consumer accepts it.
module alu_arb_sequencer #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TIMEOUT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [3:0]       req0_fun,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [3:0]       req1_fun,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   output logic             rsp_err,
   output logic             au_enable,
   output logic [3:0]       au_fun,
   output logic [WIDTH-1:0] au_a,
   output logic [WIDTH-1:0] au_b,
   input  logic [WIDTH-1:0] au_out,
   input  logic             au_carry,
   input  logic             au_flag,
   output logic             busy
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e          state;
   logic            last_grant;
   logic [CntW-1:0] wait_cnt;

   logic             any_req;
   logic             grant1;
   logic [3:0]       fun_sel;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic             illegal;

   // On a tie the requester that was not granted last time wins.
   always_comb begin
      any_req = req0_valid | req1_valid;
      grant1  = req1_valid & (~req0_valid | ~last_grant);
      fun_sel = grant1 ? req1_fun : req0_fun;
      a_sel   = grant1 ? req1_a : req0_a;
      b_sel   = grant1 ? req1_b : req0_b;
      illegal = (fun_sel > 4'd3) || ((fun_sel == 4'd3) && (b_sel == '0));
   end

   // The accept strobe is combinational; gating with rst_n keeps it low during reset.
   always_comb begin
      req0_ready = rst_n && (state == StIdle) && any_req && !grant1;
      req1_ready = rst_n && (state == StIdle) && grant1;
   end

   assign busy = (state != StIdle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         last_grant <= 1'b1;
         wait_cnt   <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         rsp_carry  <= 1'b0;
         rsp_err    <= 1'b0;
         au_enable  <= 1'b0;
         au_fun     <= '0;
         au_a       <= '0;
         au_b       <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (any_req) begin
                  last_grant <= grant1;
                  rsp_id     <= grant1;
                  au_fun     <= fun_sel;
                  au_a       <= a_sel;
                  au_b       <= b_sel;
                  if (illegal) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     rsp_carry <= 1'b0;
                     state     <= StResp;
                  end else begin
                     au_enable <= 1'b1;
                     state     <= StIssue;
                  end
               end
            end
            StIssue: begin
               au_enable <= 1'b0;
               wait_cnt  <= '0;
               state     <= StWait;
            end
            StWait: begin
               // A flag in the last allowed cycle still beats the timeout.
               if (au_flag) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= au_out;
                  rsp_carry <= au_carry;
                  state     <= StResp;
               end else if (wait_cnt == CntLast) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= '0;
                  rsp_carry <= 1'b0;
                  state     <= StResp;
               end else begin
                  wait_cnt <= wait_cnt + CntW'(1);
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arb_sequencer.sv
// Randomised and directed bench for alu_arb_sequencer with a cycle-timeline
// reference model and a behavioural arithmetic unit.
module tb_alu_arb_sequencer;
   localparam int W  = 16;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         req_valid [2];
   logic [3:0]   req_fun   [2];
   logic [W-1:0] req_a     [2];
   logic [W-1:0] req_b     [2];
   logic         r0, r1;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
   logic [W-1:0] rsp_data;
   logic         au_enable, au_carry, au_flag, busy;
   logic [3:0]   au_fun;
   logic [W-1:0] au_a, au_b, au_out;

   alu_arb_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req_valid[0]), .req0_fun(req_fun[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
      .req0_ready(r0),
      .req1_valid(req_valid[1]), .req1_fun(req_fun[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
      .req1_ready(r1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_carry(rsp_carry), .rsp_err(rsp_err),
      .au_enable(au_enable), .au_fun(au_fun), .au_a(au_a), .au_b(au_b),
      .au_out(au_out), .au_carry(au_carry), .au_flag(au_flag), .busy(busy)
   );

   int n_tests = 0, n_fail = 0;
   int cyc = 0, free_from = 0, rsp_count = 0;
   bit ptr = 1'b1;
   bit txn_act = 1'b0;
   int g_cyc, rsp_start, flag_cyc = -1;
   bit t_id, t_legal, t_carry, x_err, x_carry;
   logic [3:0]   t_fun;
   logic [W-1:0] t_a, t_b, t_res, x_data;
   int en_seen, last_lat, v_cycles;
   logic [3:0] en_fun;
   bit seen_rsp, last_id, last_err, last_carry;
   logic [W-1:0] last_data;
   int gseq[$];
   int idseq[$];
   bit refill [2];
   bit acc [2];
   bit rand_ops = 0, rand_delay = 0, rand_rdy = 0;
   int fixed_delay = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Behavioural unit: add carry-out, sub borrow, truncated mul, integer div.
   task automatic compute(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]     s;
      logic [2*W-1:0] p;
      t_carry = 1'b0;
      case (f)
         4'd0: begin s = {1'b0, a} + {1'b0, b}; t_res = s[W-1:0]; t_carry = s[W]; end
         4'd1: begin s = {1'b0, a} - {1'b0, b}; t_res = s[W-1:0]; t_carry = s[W]; end
         4'd2: begin p = a * b; t_res = p[W-1:0]; end
         4'd3: t_res = (b == 0) ? '0 : a / b;
         default: t_res = '0;
      endcase
   endtask

   task automatic start_txn(input bit g);
      int d;
      txn_act = 1; g_cyc = cyc; t_id = g;
      t_fun = req_fun[g]; t_a = req_a[g]; t_b = req_b[g];
      t_legal = (t_fun <= 3) && !(t_fun == 3 && t_b == 0);
      d = fixed_delay;
      if (rand_delay) d = ($urandom % 8 == 0) ? 0 : 1 + int'($urandom % (TO + 1));
      compute(t_fun, t_a, t_b);
      x_data = '0; x_carry = 0; x_err = 1;
      if (!t_legal) begin
         rsp_start = cyc + 1; flag_cyc = -1;
      end else if (d == 0 || d > TO) begin
         rsp_start = cyc + 2 + TO; flag_cyc = (d == 0) ? -1 : cyc + 1 + d;
      end else begin
         rsp_start = cyc + 2 + d; flag_cyc = cyc + 1 + d;
         x_err = 0; x_data = t_res; x_carry = t_carry;
      end
      en_seen = 0; seen_rsp = 0; v_cycles = 0;
   endtask

   task automatic check_cycle();
      bit er0, er1, g, een, ebusy, eval;
      er0 = 0; er1 = 0; acc[0] = 0; acc[1] = 0;
      if (!txn_act && cyc >= free_from && (req_valid[0] || req_valid[1])) begin
         if (req_valid[0] && req_valid[1]) g = ~ptr;
         else g = req_valid[1];
         ptr = g;
         if (g) er1 = 1; else er0 = 1;
         start_txn(g);
      end
      chk("req0_ready", r0, er0);
      chk("req1_ready", r1, er1);
      if (r0) begin acc[0] = 1; gseq.push_back(0); end
      if (r1) begin acc[1] = 1; gseq.push_back(1); end
      een   = txn_act && t_legal && (cyc == g_cyc + 1);
      ebusy = txn_act && (cyc > g_cyc);
      eval  = txn_act && (cyc >= rsp_start);
      chk("au_enable", au_enable, een);
      chk("busy", busy, ebusy);
      chk("rsp_valid", rsp_valid, eval);
      if (au_enable) begin en_seen++; en_fun = au_fun; end
      if (au_enable && een) begin
         chk("au_fun", au_fun, t_fun);
         chk("au_a", au_a, t_a);
         chk("au_b", au_b, t_b);
      end
      if (rsp_valid && txn_act) begin
         v_cycles++;
         if (!seen_rsp) begin seen_rsp = 1; last_lat = cyc - g_cyc; end
      end
      if (rsp_valid && eval) begin
         chk("rsp_id", rsp_id, t_id);
         chk("rsp_data", rsp_data, x_data);
         chk("rsp_carry", rsp_carry, x_carry);
         chk("rsp_err", rsp_err, x_err);
      end
      if (eval && rsp_ready) begin
         last_id = rsp_id; last_data = rsp_data; last_err = rsp_err; last_carry = rsp_carry;
         idseq.push_back(int'(rsp_id));
         rsp_count++; txn_act = 0; free_from = cyc + 1;
      end
   endtask

   task automatic new_req(input int i);
      req_valid[i] = 1;
      req_a[i] = W'($urandom);
      if (rand_ops) begin
         req_fun[i] = ($urandom % 4 == 0) ? 4'($urandom % 16) : 4'($urandom % 4);
         req_b[i] = ($urandom % 5 == 0) ? '0 : W'($urandom);
      end else begin
         req_fun[i] = 4'($urandom % 3);
         req_b[i] = W'($urandom);
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++)
         if (acc[i]) begin
            if (refill[i]) new_req(i);
            else req_valid[i] = 0;
         end
      if (cyc == flag_cyc) begin
         au_flag = 1; au_out = t_res; au_carry = t_carry;
      end else begin
         au_flag = 0; au_out = W'($urandom); au_carry = 1'($urandom % 2);
      end
      if (rand_rdy) rsp_ready = ($urandom % 3) != 0;
   endtask

   task automatic do_reset();
      #1 rst_n = 0;
      #1;
      chk("rst req0_ready", r0, 0);      chk("rst req1_ready", r1, 0);
      chk("rst rsp_valid", rsp_valid, 0); chk("rst rsp_id", rsp_id, 0);
      chk("rst rsp_data", rsp_data, 0);   chk("rst rsp_carry", rsp_carry, 0);
      chk("rst rsp_err", rsp_err, 0);     chk("rst au_enable", au_enable, 0);
      chk("rst au_fun", au_fun, 0);       chk("rst au_a", au_a, 0);
      chk("rst au_b", au_b, 0);           chk("rst busy", busy, 0);
      @(posedge clk);
      #1;
      au_flag = 0; rst_n = 1; cyc++;
      ptr = 1; txn_act = 0; flag_cyc = -1; free_from = cyc;
      acc[0] = 0; acc[1] = 0;
   endtask

   task automatic wait_done(input int budget);
      int target;
      target = rsp_count + 1;
      for (int k = 0; k < budget && rsp_count < target; k++) step();
      chk("response arrived", rsp_count, target);
   endtask

   task automatic set_req(input int i, input logic [3:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      req_valid[i] = 1; req_fun[i] = f; req_a[i] = a; req_b[i] = b;
   endtask

   initial begin
      logic [3:0] gs, is;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 0; req_fun[i] = 0; req_a[i] = 0; req_b[i] = 0;
         refill[i] = 0; acc[i] = 0;
      end
      rsp_ready = 0; au_out = 0; au_carry = 0; au_flag = 0;
      @(posedge clk);
      #1;
      do_reset();

      // Single add, one-cycle unit.
      rsp_ready = 1; fixed_delay = 1;
      set_req(0, 4'd0, 16'h0005, 16'h0003);
      wait_done(20);
      chk("add id", last_id, 0);
      chk("add data", last_data, 16'h0008);
      chk("add err", last_err, 0);
      chk("add latency", last_lat, 3);
      chk("add enable count", en_seen, 1);
      chk("add au_fun", en_fun, 0);

      // Continuous contention from reset alternates 0,1,0,1.
      do_reset();
      gseq.delete(); idseq.delete();
      refill[0] = 1; refill[1] = 1;
      new_req(0); new_req(1);
      for (int n = 0; n < 4; n++) wait_done(20);
      refill[0] = 0; refill[1] = 0; req_valid[0] = 0; req_valid[1] = 0;
      gs = '1; is = '1;
      for (int n = 0; n < 4; n++) begin
         if (gseq.size() > n) gs[n] = gseq[n][0];
         if (idseq.size() > n) is[n] = idseq[n][0];
      end
      chk("rr grant seq", gs, 4'b1010);
      chk("rr rsp_id seq", is, 4'b1010);

      // Divide by zero and undefined opcode both bypass the unit.
      set_req(1, 4'd3, 16'h0010, 16'h0000);
      wait_done(20);
      chk("div0 id", last_id, 1);
      chk("div0 err", last_err, 1);
      chk("div0 data", last_data, 0);
      chk("div0 enable count", en_seen, 0);
      chk("div0 latency", last_lat, 1);
      set_req(1, 4'hA, 16'h1111, 16'h2222);
      wait_done(20);
      chk("fun A id", last_id, 1);
      chk("fun A err", last_err, 1);
      chk("fun A data", last_data, 0);
      chk("fun A enable count", en_seen, 0);

      // Unit never answers; response held while consumer stalls.
      rsp_ready = 0; fixed_delay = 0; gseq.delete();
      set_req(0, 4'd0, 16'h0001, 16'h0002);
      set_req(1, 4'd1, 16'h0100, 16'h0001);
      for (int n = 0; n < 14; n++) step();
      chk("stall valid cycles", v_cycles, 8);
      chk("stall grants", gseq.size(), 1);
      rsp_ready = 1;
      wait_done(20);
      chk("timeout err", last_err, 1);
      chk("timeout data", last_data, 0);
      chk("timeout latency", last_lat, 2 + TO);
      fixed_delay = 1;
      wait_done(20);
      chk("after stall id", last_id, 1);
      chk("after stall data", last_data, 16'h00FF);
      chk("after stall carry", last_carry, 0);

      // Reset while waiting on the unit; pending req1 then completes.
      fixed_delay = 0;
      set_req(0, 4'd0, 16'h0007, 16'h0007);
      for (int n = 0; n < 3; n++) step();
      req_valid[0] = 0;
      set_req(1, 4'd0, 16'h1234, 16'h0001);
      do_reset();
      fixed_delay = 1;
      wait_done(20);
      chk("post reset id", last_id, 1);
      chk("post reset data", last_data, 16'h1235);
      chk("post reset err", last_err, 0);
      chk("post reset latency", last_lat, 3);

      // Random traffic with a reset in the middle.
      rand_ops = 1; rand_delay = 1; rand_rdy = 1;
      refill[0] = 1; refill[1] = 1;
      new_req(0); new_req(1);
      for (int n = 0; n < 3000; n++) begin
         step();
         if (n == 1500) do_reset();
      end
      chk("random traffic progressed", rsp_count > 200, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
